// File: rtl/dmem_subsys_if.sv
// DMEM bus between the MINA2000 memory-access stage (master) and dmem_subsys (slave).
// Address, store data and strobes are valid every cycle; read data returns in the same cycle.
interface dmem_subsys_if;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wrdata;
  logic [3:0]  dmem_wrstb;
  logic [31:0] dmem_rddata;

  modport master (
    output dmem_addr,
    output dmem_wrdata,
    output dmem_wrstb,
    input  dmem_rddata
  );

  modport slave (
    input  dmem_addr,
    input  dmem_wrdata,
    input  dmem_wrstb,
    output dmem_rddata
  );
endinterface

// File: rtl/dmem_subsys.sv
// MINA2000 data memory: byte-strobed RAM, UART TX with byte FIFO, and an optional
// cycle counter at MMIO 0x8 built only when DMEM_CYCLE_CNT_EN is defined.
module dmem_subsys #(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8,
  parameter int CLK_DIV    = 868
) (
  input  logic         clk,
  input  logic         rst_n,
  dmem_subsys_if.slave dmem,
  output logic         uart_tx
);

  localparam int RAM_AW  = $clog2(RAM_WORDS);
  localparam int FIFO_AW = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(CLK_DIV);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  localparam logic [CNT_W-1:0]   BIT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [FIFO_AW:0]   CNT_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);

  logic [31:0]       r_ram [RAM_WORDS];
  logic [7:0]        r_fifo [FIFO_DEPTH];
  logic [FIFO_AW-1:0] r_wr_ptr;
  logic [FIFO_AW-1:0] r_rd_ptr;
  logic [FIFO_AW:0]  r_count;
  logic              r_ovf;
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [2:0]        r_bit_idx;
  logic [7:0]        r_shift;
  logic              r_tx;

  logic              w_sel_mmio;
  logic [1:0]        w_reg;
  logic [RAM_AW-1:0] w_ram_idx;
  logic              w_push_req;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_busy;
  logic              w_ovf_clr;
  logic [31:0]       w_status;
  logic [31:0]       w_cycle;
  logic [31:0]       w_rddata;
  logic              w_unused_addr;

  assign w_sel_mmio = dmem.dmem_addr[31];
  assign w_reg      = dmem.dmem_addr[3:2];
  assign w_ram_idx  = dmem.dmem_addr[RAM_AW+1:2];
  assign w_unused_addr = ^{dmem.dmem_addr[30:RAM_AW+2], dmem.dmem_addr[1:0]};

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_busy  = (r_state != ST_IDLE);

  // full/empty are pre-edge values, so a push while full drops even if a pop happens.
  assign w_push_req = w_sel_mmio & (w_reg == 2'd0) & dmem.dmem_wrstb[0];
  assign w_push     = w_push_req & ~w_full;
  assign w_pop      = (r_state == ST_IDLE) & ~w_empty;
  assign w_ovf_clr  = w_sel_mmio & (w_reg == 2'd1) & dmem.dmem_wrstb[0] & dmem.dmem_wrdata[3];

  assign w_status = {28'd0, r_ovf, w_busy, w_empty, w_full};

  // RAM storage: per-lane writes, no reset on contents
  always_ff @(posedge clk) begin
    if (!w_sel_mmio) begin
      for (int i = 0; i < 4; i++) begin
        if (dmem.dmem_wrstb[i]) begin
          r_ram[w_ram_idx][8*i +: 8] <= dmem.dmem_wrdata[8*i +: 8];
        end
      end
    end
  end

  // TX FIFO byte storage
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= dmem.dmem_wrdata[7:0];
    end
  end

  // TX FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + FIFO_AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + FIFO_AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (FIFO_AW + 1)'(1);
        2'b01:   r_count <= r_count - (FIFO_AW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push_req && w_full) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end else begin
        r_ovf <= r_ovf;
      end
    end
  end

  // UART transmit FSM; r_tx carries the level of the bit currently on the line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'd0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          r_bit_idx <= 3'd0;
          if (w_pop) begin
            r_shift <= r_fifo[r_rd_ptr];
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt <= '0;
            r_tx      <= r_shift[0];
            r_state   <= ST_DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        ST_DATA: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_bit_idx <= 3'd0;
              r_tx      <= 1'b1;
              r_state   <= ST_STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx      <= r_shift[1];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        ST_STOP: begin
          if (r_bit_cnt == BIT_LAST) begin
            r_bit_cnt <= '0;
            r_state   <= ST_IDLE;
          end else begin
            r_bit_cnt <= r_bit_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_bit_cnt <= '0;
          r_bit_idx <= 3'd0;
          r_tx      <= 1'b1;
        end
      endcase
    end
  end

  assign uart_tx = r_tx;

`ifdef DMEM_CYCLE_CNT_EN
  logic [31:0] r_cycle;
  logic        w_cyc_wr;

  assign w_cyc_wr = w_sel_mmio & (w_reg == 2'd2) & (|dmem.dmem_wrstb);

  // Free-running cycle counter; a strobed write replaces the strobed lanes for this edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle <= 32'd0;
    end else if (w_cyc_wr) begin
      for (int i = 0; i < 4; i++) begin
        r_cycle[8*i +: 8] <= dmem.dmem_wrstb[i] ? dmem.dmem_wrdata[8*i +: 8] : r_cycle[8*i +: 8];
      end
    end else begin
      r_cycle <= r_cycle + 32'd1;
    end
  end

  assign w_cycle = r_cycle;
`else
  assign w_cycle = 32'd0;
`endif

  // Combinational read mux; reads never change state
  always_comb begin
    w_rddata = 32'd0;
    if (!w_sel_mmio) begin
      w_rddata = r_ram[w_ram_idx];
    end else begin
      case (w_reg)
        2'd1:    w_rddata = w_status;
        2'd2:    w_rddata = w_cycle;
        default: w_rddata = 32'd0;
      endcase
    end
  end

  assign dmem.dmem_rddata = w_rddata;

endmodule

// File: tb/tb_dmem_subsys.sv
// Directed bench for dmem_subsys with RAM_WORDS=64, FIFO_DEPTH=8, CLK_DIV=4.
module tb_dmem_subsys;

  localparam logic [31:0] A_DATA = 32'h8000_0000;
  localparam logic [31:0] A_STAT = 32'h8000_0004;
  localparam logic [31:0] A_CYC  = 32'h8000_0008;
  localparam logic [31:0] A_RSVD = 32'h8000_000C;

  logic clk = 1'b0;
  logic rst_n;
  logic uart_tx;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  dmem_subsys_if u_bus ();

  dmem_subsys #(
    .RAM_WORDS (64),
    .FIFO_DEPTH(8),
    .CLK_DIV   (4)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .dmem   (u_bus),
    .uart_tx(uart_tx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] stb);
    @(negedge clk);
    u_bus.dmem_addr   = a;
    u_bus.dmem_wrdata = d;
    u_bus.dmem_wrstb  = stb;
    @(posedge clk);
    #1;
    u_bus.dmem_wrstb  = 4'h0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    u_bus.dmem_addr  = a;
    u_bus.dmem_wrstb = 4'h0;
    #1;
    d = u_bus.dmem_rddata;
  endtask

  // Waits for a start bit and samples each bit mid-period
  task automatic recv_frame(output logic [7:0] b, output int t);
    bit found;
    found = 1'b0;
    b = 8'h00;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) found = 1'b1;
    end
    check_eq("rx_start_seen", {31'd0, found}, 32'd1);
    t = cyc;
    repeat (2) @(negedge clk);
    check_eq("rx_start_bit", {31'd0, uart_tx}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (4) @(negedge clk);
      b[i] = uart_tx;
    end
    repeat (4) @(negedge clk);
    check_eq("rx_stop_bit", {31'd0, uart_tx}, 32'd1);
  endtask

  function automatic logic exp_frame_bit(input int k, input logic [7:0] b);
    if (k >= 1 && k <= 4) return 1'b0;
    else if (k >= 5 && k <= 36) return b[(k - 5) / 4];
    else return 1'b1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, got no summary, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  b1, b2;
    int          t1, t2, lows;
    bit          found;
    logic [7:0]  ovf_bytes [10];
    logic [7:0]  rx_bytes [9];

    ovf_bytes = '{8'h3C, 8'hC3, 8'h00, 8'hFF, 8'h5A, 8'h81, 8'h7E, 8'h18, 8'hE7, 8'h99};

    rst_n = 1'b0;
    u_bus.dmem_addr   = 32'd0;
    u_bus.dmem_wrdata = 32'd0;
    u_bus.dmem_wrstb  = 4'h0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // reset state
    check_eq("rst_uart_tx", {31'd0, uart_tx}, 32'd1);
    bus_read(A_STAT, d);              check_eq("rst_status", d, 32'h2);
    bus_read(A_DATA, d);              check_eq("rst_data_reg", d, 32'h0);
    bus_read(A_RSVD, d);              check_eq("rsvd_reg", d, 32'h0);
    bus_read(32'h8000_0014, d);       check_eq("mmio_alias_status", d, 32'h2);

    // RAM byte strobes and aliasing
    bus_write(32'h10, 32'hAABB_CCDD, 4'hF);
    bus_write(32'h10, 32'h1122_3344, 4'h5);
    bus_read(32'h10, d);              check_eq("ram_strobe", d, 32'hAA22_CC44);
    bus_read(32'h110, d);             check_eq("ram_alias_depth", d, 32'hAA22_CC44);
    bus_read(32'h7FFF_FF10, d);       check_eq("ram_alias_high", d, 32'hAA22_CC44);
    bus_write(32'h20, 32'h0000_0000, 4'hF);
    bus_write(32'h20, 32'hDEAD_BEEF, 4'h8);
    bus_read(32'h20, d);              check_eq("ram_lane3", d, 32'hDE00_0000);
    bus_write(32'h20, 32'h0000_5A00, 4'h2);
    bus_read(32'h20, d);              check_eq("ram_lane1", d, 32'hDE00_5A00);

    // UART_DATA write without lane 0 pushes nothing; reserved write ignored
    bus_write(A_DATA, 32'h0000_0077, 4'h2);
    bus_write(A_RSVD, 32'hFFFF_FFFF, 4'hF);
    bus_read(A_STAT, d);              check_eq("no_push_lane1", d, 32'h2);
    bus_read(A_RSVD, d);              check_eq("rsvd_after_write", d, 32'h0);

    // single frame, 0xA5, tx and busy checked every cycle
    bus_write(A_DATA, 32'h0000_00A5, 4'h1);
    u_bus.dmem_addr = A_STAT;
    for (int k = 0; k <= 41; k++) begin
      @(negedge clk);
      #1;
      check_eq($sformatf("frame_tx[%0d]", k), {31'd0, uart_tx}, {31'd0, exp_frame_bit(k, 8'hA5)});
      check_eq($sformatf("frame_busy[%0d]", k), {31'd0, u_bus.dmem_rddata[2]},
               {31'd0, (k >= 1 && k <= 40)});
    end

    // back-to-back frames: byte period 10*CLK_DIV+1
    bus_write(A_DATA, 32'h0000_0001, 4'h1);
    bus_write(A_DATA, 32'h0000_0002, 4'h1);
    recv_frame(b1, t1);
    recv_frame(b2, t2);
    check_eq("b2b_byte0", {24'd0, b1}, 32'h01);
    check_eq("b2b_byte1", {24'd0, b2}, 32'h02);
    check_eq("b2b_period", t2 - t1, 32'd41);
    repeat (4) @(negedge clk);

    // overflow: 10 pushes, 9 accepted while TX drains
    fork
      begin
        for (int i = 0; i < 10; i++) bus_write(A_DATA, {24'd0, ovf_bytes[i]}, 4'h1);
        bus_read(A_STAT, d);          check_eq("ovf_status", d, 32'hD);
        bus_write(A_STAT, 32'h7, 4'h1);
        bus_read(A_STAT, d);          check_eq("ovf_no_clear_bit3_0", d, 32'hD);
        bus_write(A_STAT, 32'h8, 4'h2);
        bus_read(A_STAT, d);          check_eq("ovf_no_clear_lane1", d, 32'hD);
        bus_write(A_STAT, 32'h8, 4'h1);
        bus_read(A_STAT, d);          check_eq("ovf_cleared", d, 32'h5);
      end
      begin
        for (int i = 0; i < 9; i++) recv_frame(rx_bytes[i], t1);
      end
    join
    for (int i = 0; i < 9; i++) begin
      check_eq($sformatf("ovf_rx[%0d]", i), {24'd0, rx_bytes[i]}, {24'd0, ovf_bytes[i]});
    end
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) lows++;
    end
    check_eq("ovf_dropped_no_tx", lows, 32'd0);
    bus_read(A_STAT, d);              check_eq("ovf_drained_status", d, 32'h2);

    // reset during DATA
    bus_write(32'h40, 32'hCAFE_F00D, 4'hF);
    bus_write(A_DATA, 32'h0000_0000, 4'h1);
    bus_write(A_DATA, 32'h0000_0055, 4'h1);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) found = 1'b1;
    end
    check_eq("pre_rst_start", {31'd0, found}, 32'd1);
    repeat (6) @(negedge clk);
    check_eq("pre_rst_data_low", {31'd0, uart_tx}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_tx", {31'd0, uart_tx}, 32'd1);
    u_bus.dmem_addr = A_STAT;
    #1;
    check_eq("rst_mid_status", u_bus.dmem_rddata, 32'h2);
    @(negedge clk);
    rst_n = 1'b1;
    bus_read(32'h40, d);              check_eq("rst_ram_keep0", d, 32'hCAFE_F00D);
    bus_read(32'h10, d);              check_eq("rst_ram_keep1", d, 32'hAA22_CC44);
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (uart_tx === 1'b0) lows++;
    end
    check_eq("rst_fifo_flushed", lows, 32'd0);
    bus_read(A_STAT, d);              check_eq("rst_post_status", d, 32'h2);

    // cycle counter
`ifdef DMEM_CYCLE_CNT_EN
    bus_write(A_CYC, 32'hFFFF_FFFE, 4'hF);
    bus_read(A_CYC, d);               check_eq("cyc_loaded", d, 32'hFFFF_FFFE);
    bus_read(A_CYC, d);               check_eq("cyc_next", d, 32'hFFFF_FFFF);
    bus_read(A_CYC, d);               check_eq("cyc_wrap", d, 32'h0000_0000);
`else
    bus_write(A_CYC, 32'hFFFF_FFFE, 4'hF);
    bus_read(A_CYC, d);               check_eq("cyc_absent0", d, 32'h0);
    bus_read(A_CYC, d);               check_eq("cyc_absent1", d, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
